// File: rtl/note_scheduler_pkg.sv
// Shared types and constants for the note scheduler: FSM state encoding,
// the rest/end-marker table codes and the default clock/unit derivation.
package note_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_PLAY  = 3'd3,
      ST_PAUSE = 3'd4
   } state_t;

   localparam int unsigned REST_PERIOD     = 1;
   localparam int unsigned END_DUR         = 0;
   localparam int unsigned DEF_CLK_HZ      = 100_000_000;
   localparam int unsigned DEF_UNIT_CYCLES = DEF_CLK_HZ / 8;

   // Width that holds dur * unit_cycles for any dur of dur_w bits.
   function automatic int unsigned timer_width(input int unsigned dur_w,
                                               input int unsigned unit_cycles);
      return dur_w + $clog2(unit_cycles);
   endfunction

endpackage

// File: rtl/note_scheduler_dur_timer.sv
// Loadable down-counter that times one note; done_flag marks the last
// counting cycle so the sequencer can leave PLAY on the same edge.
module dur_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             count,
   input  logic             hold,
   output logic [WIDTH-1:0] value,
   output logic             done_flag
);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         value <= '0;
      end else if (load) begin
         value <= load_value;
      end else if (count && !hold && (value != '0)) begin
         value <= value - WIDTH'(1);
      end
   end

   // A value of 0 while counting can only follow a bad load; end the note anyway.
   assign done_flag = count && !hold && (value <= WIDTH'(1));

endmodule

// File: rtl/note_scheduler.sv
// Note table sequencer driving the tone generator period/enable.
// Optional build macro NOTE_GAP_EN mutes the last GAP_CYCLES of every note.
//
// state    | meaning
// IDLE     | stopped, outputs at reset values, waits for armed play
// FETCH    | rom_addr presented, table data arrives next cycle
// LOAD     | capture period/duration, load timer, detect end marker
// PLAY     | tone running, timer counting down
// PAUSE    | play low, timer held, tone off
module note_scheduler
   import note_sched_pkg::*;
#(
   parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
   parameter int unsigned UNIT_CYCLES = DEF_UNIT_CYCLES,
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned PERIOD_W    = 20,
   parameter int unsigned DUR_W       = 5,
   parameter int unsigned GAP_CYCLES  = 1_000_000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                play,
   input  logic                stop,
   input  logic                loop_en,
   input  logic [ADDR_W-1:0]   song_len,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [PERIOD_W-1:0] rom_period,
   input  logic [DUR_W-1:0]    rom_dur,
   output logic [PERIOD_W-1:0] tone_period,
   output logic                tone_en,
   output logic [ADDR_W-1:0]   note_index,
   output logic                busy,
   output logic                done
);

   localparam int unsigned TW = timer_width(DUR_W, UNIT_CYCLES);

   state_t          state;
   logic            armed;
   logic [TW-1:0]   dur_cycles;
   logic [TW-1:0]   timer_value;
   logic            timer_done;
   logic            end_marker;
   logic            last_note;
   logic [ADDR_W:0] next_count;
   logic            gap_mute;
   logic            unused_cfg;

   assign dur_cycles = TW'(rom_dur) * TW'(UNIT_CYCLES);
   assign end_marker = (rom_dur == DUR_W'(END_DUR));
   assign next_count = (ADDR_W + 1)'(note_index) + (ADDR_W + 1)'(1);
   assign last_note  = (next_count >= {1'b0, song_len});

   dur_timer #(
      .WIDTH (TW)
   ) u_dur_timer (
      .clock      (clock),
      .reset      (reset),
      .clear      (stop),
      .load       ((state == ST_LOAD) && !end_marker && !stop),
      .load_value (dur_cycles),
      .count      (state == ST_PLAY),
      .hold       (state == ST_PAUSE),
      .value      (timer_value),
      .done_flag  (timer_done)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         note_index  <= '0;
         tone_period <= '0;
         done        <= 1'b0;
         armed       <= 1'b1;
      end else begin
         done <= 1'b0;
         if (!play) begin
            armed <= 1'b1;
         end
         if (stop) begin
            // A held play must be released before the song can restart.
            state       <= ST_IDLE;
            note_index  <= '0;
            tone_period <= '0;
            armed       <= !play;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (play && armed) begin
                     if (song_len == '0) begin
                        done  <= 1'b1;
                        armed <= 1'b0;
                     end else begin
                        state <= ST_FETCH;
                     end
                  end
               end
               ST_FETCH: begin
                  state <= ST_LOAD;
               end
               ST_LOAD: begin
                  if (end_marker) begin
                     note_index <= '0;
                     if (loop_en) begin
                        state <= ST_FETCH;
                     end else begin
                        state       <= ST_IDLE;
                        tone_period <= '0;
                        done        <= 1'b1;
                        armed       <= 1'b0;
                     end
                  end else begin
                     tone_period <= rom_period;
                     state       <= play ? ST_PLAY : ST_PAUSE;
                  end
               end
               ST_PLAY: begin
                  if (timer_done) begin
                     if (last_note) begin
                        note_index <= '0;
                        if (loop_en) begin
                           state <= ST_FETCH;
                        end else begin
                           state       <= ST_IDLE;
                           tone_period <= '0;
                           done        <= 1'b1;
                           armed       <= 1'b0;
                        end
                     end else begin
                        note_index <= next_count[ADDR_W-1:0];
                        state      <= ST_FETCH;
                     end
                  end else if (!play) begin
                     state <= ST_PAUSE;
                  end
               end
               ST_PAUSE: begin
                  if (play) begin
                     state <= ST_PLAY;
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

`ifdef NOTE_GAP_EN
   assign gap_mute = (64'(timer_value) <= 64'(GAP_CYCLES));
`else
   assign gap_mute = 1'b0;
`endif

   // Parameters kept for documentation only in some builds.
   assign unused_cfg = ^{32'(CLK_HZ), 32'(GAP_CYCLES)};

   assign rom_addr = note_index;
   assign busy     = (state != ST_IDLE);
   assign tone_en  = (state == ST_PLAY)
                     && (tone_period != PERIOD_W'(REST_PERIOD))
                     && !gap_mute;

endmodule
